multiwave_oscillator: RTL and testbench

MULTIWAVE_OSCILLATOR -- requirements
Module: multiwave_oscillator

---
 rtl/multiwave_oscillator.sv | 108 ++++++++++
 tb/tb_multiwave_oscillator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multiwave_oscillator.sv
// Phase-accumulator oscillator producing saw / triangle / pulse / reverse-saw samples.
// Latency: amp_out/valid_out are registered one cycle after the step_in edge, computed from the pre-update phase.
// Backpressure: none; step_in may be high every cycle and every step yields a sample.
module multiwave_oscillator #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 24
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             step_in,
  input  logic [ACC_W-1:0] phase_incr_in,
  input  logic [1:0]       wave_sel_in,
  input  logic [ACC_W-1:0] pulse_width_in,
  input  logic             sync_in,
  output logic [OUT_W-1:0] amp_out,
  output logic             valid_out,
  output logic             wrap_out
);

  localparam logic [1:0] SEL_SAW   = 2'd0;
  localparam logic [1:0] SEL_TRI   = 2'd1;
  localparam logic [1:0] SEL_PULSE = 2'd2;

  localparam logic [OUT_W-1:0] AMP_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] AMP_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] MSB_BIT = {1'b1, {(ACC_W-1){1'b0}}};

  // Phase and the shadow copies of the controls; the datapath only ever sees the shadows,
  // so control changes land on a period boundary (wrap), a sync, or reset.
  logic [ACC_W-1:0] r_p;
  logic [ACC_W-1:0] r_incr_s;
  logic [1:0]       r_sel_s;
  logic [ACC_W-1:0] r_pw_s;
  logic [OUT_W-1:0] r_amp;
  logic             r_valid;
  logic             r_wrap;

  logic [ACC_W-1:0] w_p_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_u;
  logic [ACC_W-1:0] w_x;
  logic [OUT_W-1:0] w_amp;

  assign {w_carry, w_p_sum} = {1'b0, r_p} + {1'b0, r_incr_s};

  // Unsigned shape u per waveform; the offset-binary to two's-complement flip is the MSB XOR.
  always_comb begin
    w_u = ~r_p;
    case (r_sel_s)
      SEL_SAW: w_u = r_p;
      SEL_TRI: w_u = r_p[ACC_W-1] ? {~r_p[ACC_W-2:0], 1'b0} : {r_p[ACC_W-2:0], 1'b0};
      default: w_u = ~r_p;
    endcase
    w_x = w_u ^ MSB_BIT;
    if (r_sel_s == SEL_PULSE) begin
      w_amp = (r_p < r_pw_s) ? AMP_MAX : AMP_MIN;
    end else begin
      w_amp = w_x[ACC_W-1 -: OUT_W];
    end
  end

  // Truncated low bits of the shaped phase are intentionally discarded (no rounding).
  generate
    if (OUT_W < ACC_W) begin : g_trunc
      logic w_unused_low;
      assign w_unused_low = &{1'b0, w_x[ACC_W-OUT_W-1:0]};
    end
  endgenerate

  // Phase advance, shadow reload on wrap/sync, and registered sample output.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_p      <= '0;
      r_incr_s <= phase_incr_in;
      r_sel_s  <= wave_sel_in;
      r_pw_s   <= pulse_width_in;
      r_amp    <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap  <= 1'b0;
      r_valid <= step_in;
      if (step_in) begin
        r_amp <= w_amp;
      end
      if (sync_in) begin
        r_p      <= '0;
        r_incr_s <= phase_incr_in;
        r_sel_s  <= wave_sel_in;
        r_pw_s   <= pulse_width_in;
        r_wrap   <= 1'b1;
      end else if (step_in) begin
        r_p <= w_p_sum;
        if (w_carry) begin
          r_incr_s <= phase_incr_in;
          r_sel_s  <= wave_sel_in;
          r_pw_s   <= pulse_width_in;
          r_wrap   <= 1'b1;
        end
      end
    end
  end

  assign amp_out   = r_amp;
  assign valid_out = r_valid;
  assign wrap_out  = r_wrap;

endmodule

// File: tb/tb_multiwave_oscillator.sv
module tb_multiwave_oscillator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        step_in;
  logic [31:0] phase_incr_in;
  logic [1:0]  wave_sel_in;
  logic [31:0] pulse_width_in;
  logic        sync_in;
  logic [23:0] amp_out;
  logic        valid_out;
  logic        wrap_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  multiwave_oscillator #(.ACC_W(32), .OUT_W(24)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .step_in        (step_in),
    .phase_incr_in  (phase_incr_in),
    .wave_sel_in    (wave_sel_in),
    .pulse_width_in (pulse_width_in),
    .sync_in        (sync_in),
    .amp_out        (amp_out),
    .valid_out      (valid_out),
    .wrap_out       (wrap_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reset for n cycles with the given controls, leaving the bench at a falling edge.
  task automatic do_reset(input int n, input logic [31:0] incr, input logic [1:0] sel,
                          input logic [31:0] pw);
    phase_incr_in  = incr;
    wave_sel_in    = sel;
    pulse_width_in = pw;
    rst_in  = 1'b1;
    step_in = 1'b0;
    sync_in = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
    chk("rst_amp",   {8'd0, amp_out}, 32'h0);
    chk("rst_valid", {31'd0, valid_out}, 32'h0);
    chk("rst_wrap",  {31'd0, wrap_out}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // One step cycle; checks the sample and wrap flag registered at that edge.
  task automatic step_chk(input string tag, input logic [23:0] exp_amp, input logic exp_wrap);
    step_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk({tag, "_amp"},   {8'd0, amp_out}, {8'd0, exp_amp});
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'h1);
    chk({tag, "_wrap"},  {31'd0, wrap_out}, {31'd0, exp_wrap});
    @(negedge clk_in);
    step_in = 1'b0;
  endtask

  // One idle cycle; amp_out must hold, valid and wrap low.
  task automatic idle_chk(input string tag, input logic [23:0] hold_amp);
    step_in = 1'b0;
    @(posedge clk_in);
    #1;
    chk({tag, "_amp"},   {8'd0, amp_out}, {8'd0, hold_amp});
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'h0);
    chk({tag, "_wrap"},  {31'd0, wrap_out}, 32'h0);
    @(negedge clk_in);
  endtask

  initial begin
    rst_in = 1'b1; step_in = 1'b0; sync_in = 1'b0;
    phase_incr_in = '0; wave_sel_in = '0; pulse_width_in = '0;
    @(negedge clk_in);

    // Saw, quarter-period increment: wrap after 4th step.
    do_reset(3, 32'h4000_0000, 2'd0, 32'h0);
    step_chk("saw1", 24'h800000, 1'b0);
    step_chk("saw2", 24'hC00000, 1'b0);
    step_chk("saw3", 24'h000000, 1'b0);
    step_chk("saw4", 24'h400000, 1'b1);
    step_chk("saw5", 24'h800000, 1'b0);
    idle_chk("saw_idle", 24'h800000);

    // Triangle, eighth-period increment.
    do_reset(2, 32'h2000_0000, 2'd1, 32'h0);
    step_chk("tri1", 24'h800000, 1'b0);
    step_chk("tri2", 24'hC00000, 1'b0);
    step_chk("tri3", 24'h000000, 1'b0);
    step_chk("tri4", 24'h400000, 1'b0);
    step_chk("tri5", 24'h7FFFFF, 1'b0);

    // Pulse at 50% width.
    do_reset(2, 32'h4000_0000, 2'd2, 32'h8000_0000);
    step_chk("pul1", 24'h7FFFFF, 1'b0);
    step_chk("pul2", 24'h7FFFFF, 1'b0);
    step_chk("pul3", 24'h800000, 1'b0);
    step_chk("pul4", 24'h800000, 1'b1);

    // Increment change mid-period only takes effect after the wrap.
    do_reset(2, 32'h4000_0000, 2'd0, 32'h0);
    step_chk("shd1", 24'h800000, 1'b0);
    step_chk("shd2", 24'hC00000, 1'b0);
    phase_incr_in = 32'h8000_0000;
    step_chk("shd3", 24'h000000, 1'b0);
    step_chk("shd4", 24'h400000, 1'b1);
    step_chk("shd5", 24'h800000, 1'b0);
    step_chk("shd6", 24'h000000, 1'b1);
    step_chk("shd7", 24'h800000, 1'b0);

    // Hard sync at p=0x80000000 switching to pulse mode.
    do_reset(2, 32'h4000_0000, 2'd0, 32'hC000_0000);
    step_chk("syn1", 24'h800000, 1'b0);
    step_chk("syn2", 24'hC00000, 1'b0);
    wave_sel_in = 2'd2;
    sync_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("syn_wrap",  {31'd0, wrap_out}, 32'h1);
    chk("syn_valid", {31'd0, valid_out}, 32'h0);
    @(negedge clk_in);
    sync_in = 1'b0;
    step_chk("syn3", 24'h7FFFFF, 1'b0);

    // Reset mid-period with step high; switch to reverse saw while in reset.
    do_reset(2, 32'h4000_0000, 2'd0, 32'h0);
    step_chk("mrs1", 24'h800000, 1'b0);
    step_chk("mrs2", 24'hC00000, 1'b0);
    rst_in = 1'b1;
    step_in = 1'b1;
    wave_sel_in = 2'd3;
    @(posedge clk_in);
    #1;
    chk("mrs_amp",   {8'd0, amp_out}, 32'h0);
    chk("mrs_valid", {31'd0, valid_out}, 32'h0);
    chk("mrs_wrap",  {31'd0, wrap_out}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step_chk("mrs3", 24'h7FFFFF, 1'b0);
    step_chk("mrs4", 24'h3FFFFF, 1'b0);

    // Zero increment (DC) with zero pulse width: constant minimum, never wraps.
    do_reset(2, 32'h0, 2'd2, 32'h0);
    step_chk("dc1", 24'h800000, 1'b0);
    phase_incr_in = 32'h4000_0000;
    wave_sel_in = 2'd0;
    step_chk("dc2", 24'h800000, 1'b0);
    step_chk("dc3", 24'h800000, 1'b0);

    // Full-scale pulse width: max except at p = 2^32-1.
    do_reset(2, 32'hFFFF_FFFF, 2'd2, 32'hFFFF_FFFF);
    step_chk("pwf1", 24'h7FFFFF, 1'b0);
    step_chk("pwf2", 24'h800000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
